// File: rtl/cmos_ddr_pack_if.sv
// Camera-side capture bus: DVP input stream plus DDR write and frame status.
interface cmos_ddr_pack_if;
  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  logic        ddr_init_done;
  logic        ddr_wren;
  logic [63:0] ddr_wdata;
  logic        frame_start;
  logic        frame_done;
  logic [19:0] frame_words;
  logic        line_err;

  modport master (
    output cmos_vsync, cmos_href, cmos_data, ddr_init_done,
    input  ddr_wren, ddr_wdata, frame_start, frame_done, frame_words, line_err
  );

  modport slave (
    input  cmos_vsync, cmos_href, cmos_data, ddr_init_done,
    output ddr_wren, ddr_wdata, frame_start, frame_done, frame_words, line_err
  );
endinterface

// File: rtl/cmos_ddr_pack.sv
// OV5640 DVP capture: pairs RGB565 bytes into pixels, packs four pixels per
// 64-bit DDR word, gates on DDR init and skips the camera's settling frames.
module cmos_ddr_pack #(
  parameter int SKIP_FRAMES = 10,
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720
) (
  input  logic          cmos_clk,
  input  logic          cmos_rst,
  cmos_ddr_pack_if.slave bus
);
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int SW = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SKIP = 2'd2;
  localparam logic [1:0] S_CAP  = 2'd3;

  logic          vsync_q, vsync_qq, href_q, href_qq;
  logic [7:0]    data_q;
  logic          vs_rise, hr_rise, hr_fall;
  logic [1:0]    state;
  logic [SW-1:0] skip_cnt;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] line_y;
  logic          phase;
  logic [1:0]    pig;
  logic [7:0]    hi_byte;
  logic [47:0]   pack;
  logic [19:0]   word_cnt;
  logic          wren, fstart, fdone, lerr;
  logic [63:0]   wdata;
  logic [19:0]   fwords;
  logic [15:0]   pixel;
  logic          x_ok, pix_ok;

  assign vs_rise = vsync_q & ~vsync_qq;
  assign hr_rise = href_q & ~href_qq;
  assign hr_fall = ~href_q & href_qq;
  assign pixel   = {hi_byte, data_q};
  assign x_ok    = pix_x < XW'(H_ACTIVE);
  assign pix_ok  = x_ok && (line_y < YW'(V_ACTIVE));

  assign bus.ddr_wren    = wren;
  assign bus.ddr_wdata   = wdata;
  assign bus.frame_start = fstart;
  assign bus.frame_done  = fdone;
  assign bus.frame_words = fwords;
  assign bus.line_err    = lerr;

  // Register sync inputs for edge detect; data delayed to line up with href_q.
  always_ff @(posedge cmos_clk or posedge cmos_rst) begin
    if (cmos_rst) begin
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      href_q   <= 1'b0;
      href_qq  <= 1'b0;
      data_q   <= 8'd0;
    end else begin
      vsync_q  <= bus.cmos_vsync;
      vsync_qq <= vsync_q;
      href_q   <= bus.cmos_href;
      href_qq  <= href_q;
      data_q   <= bus.cmos_data;
    end
  end

  // Capture FSM with byte pairing, line limits, word packing and frame status.
  always_ff @(posedge cmos_clk or posedge cmos_rst) begin
    if (cmos_rst) begin
      state    <= S_IDLE;
      skip_cnt <= '0;
      pix_x    <= '0;
      line_y   <= '0;
      phase    <= 1'b0;
      pig      <= 2'd0;
      hi_byte  <= 8'd0;
      pack     <= 48'd0;
      word_cnt <= 20'd0;
      wren     <= 1'b0;
      wdata    <= 64'd0;
      fstart   <= 1'b0;
      fdone    <= 1'b0;
      fwords   <= 20'd0;
      lerr     <= 1'b0;
    end else begin
      wren   <= 1'b0;
      fstart <= 1'b0;
      fdone  <= 1'b0;

      // line position tracking runs in every state so it is valid on entry to CAP
      if (vs_rise)
        line_y <= '0;
      else if (hr_fall && line_y < YW'(V_ACTIVE))
        line_y <= line_y + 1'b1;
      if (hr_rise) begin
        pix_x <= '0;
        phase <= 1'b0;
      end

      if (!bus.ddr_init_done) begin
        // losing DDR drops the partial word silently; no frame_done
        state <= S_IDLE;
        phase <= 1'b0;
        pig   <= 2'd0;
      end else begin
        case (state)
          S_IDLE: state <= S_WAIT;
          S_WAIT: if (vs_rise) begin
            if (SKIP_FRAMES == 0) begin
              state    <= S_CAP;
              fstart   <= 1'b1;
              word_cnt <= 20'd0;
              lerr     <= 1'b0;
              pig      <= 2'd0;
              phase    <= 1'b0;
            end else begin
              state    <= S_SKIP;
              skip_cnt <= '0;
            end
          end
          S_SKIP: if (vs_rise) begin
            if (skip_cnt == SW'(SKIP_FRAMES - 1)) begin
              state    <= S_CAP;
              fstart   <= 1'b1;
              word_cnt <= 20'd0;
              lerr     <= 1'b0;
              pig      <= 2'd0;
              phase    <= 1'b0;
            end else begin
              skip_cnt <= skip_cnt + 1'b1;
            end
          end
          S_CAP: begin
            if (vs_rise) begin
              // frame boundary; a line cut short by vsync still flags an error
              fdone    <= 1'b1;
              fwords   <= word_cnt;
              word_cnt <= 20'd0;
              fstart   <= 1'b1;
              pig      <= 2'd0;
              phase    <= 1'b0;
              lerr     <= href_q | (hr_fall & (phase | (pig != 2'd0)));
            end else if (href_q) begin
              if (phase && !hr_rise) begin
                phase <= 1'b0;
                if (x_ok) pix_x <= pix_x + 1'b1;
                if (pix_ok) begin
                  pig <= pig + 1'b1;
                  case (pig)
                    2'd0: pack[47:32] <= pixel;
                    2'd1: pack[31:16] <= pixel;
                    2'd2: pack[15:0]  <= pixel;
                    default: begin
                      wren  <= 1'b1;
                      wdata <= {pack, pixel};
                      if (word_cnt != 20'hFFFFF) word_cnt <= word_cnt + 1'b1;
                    end
                  endcase
                end
              end else begin
                hi_byte <= data_q;
                phase   <= 1'b1;
              end
            end else if (hr_fall) begin
              if (phase || pig != 2'd0) lerr <= 1'b1;
              phase <= 1'b0;
              pig   <= 2'd0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/cmos_ddr_pack.md
Name: cmos_ddr_pack

Overview:
- Capture-side counterpart of the VGA display unpacker, in the OV5640 camera clock domain.
- Samples the camera's 8-bit DVP stream (RGB565, two bytes per pixel), builds 16-bit pixels and packs four pixels into one 64-bit DDR write word.
- Issues a one-cycle write strobe per word and reports frame boundaries, word counts and line-length errors.
- Gates capture on DDR initialisation and discards the camera's first settling frames.

Parameters:
- SKIP_FRAMES, 10: number of complete frames discarded after DDR init before capture starts.
- H_ACTIVE, 1280: pixels per line accepted; further pixels in a line are ignored.
- V_ACTIVE, 720: lines per frame accepted; further lines are ignored.

Ports:
- cmos_clk, input, 1: camera pixel clock; all logic on rising edge.
- cmos_rst, input, 1: reset; asynchronous, active-high.
- cmos_vsync, input, 1: frame sync, active-high; rising edge marks frame start.
- cmos_href, input, 1: line valid, active-high.
- cmos_data, input, 8: pixel byte.
- ddr_init_done, input, 1: DDR ready.
- ddr_wren, output, 1: one-cycle write strobe.
- ddr_wdata, output, 64: packed word, valid when ddr_wren=1.
- frame_start, output, 1: one-cycle pulse when a captured frame begins.
- frame_done, output, 1: one-cycle pulse when a captured frame ends.
- frame_words, output, 20: words written in the last completed frame; updated with frame_done.
- line_err, output, 1: sticky; set on a malformed line, cleared at frame_start.

Behaviour:
- Reset values: every output is 0. FSM=IDLE. All counters, the pack register and the byte-phase bit are 0.
- Input registering: cmos_vsync and cmos_href are registered once for edge detect. vs_rise = vsync_q & ~vsync_qq. hr_rise and hr_fall are formed the same way.
- Byte datapath: cmos_data is delayed by one register, aligned with href_q.
- FSM transitions:
  - IDLE -> WAIT when ddr_init_done=1.
  - WAIT -> SKIP on vs_rise; skip_cnt=0.
  - SKIP: each vs_rise increments skip_cnt. On the vs_rise where skip_cnt==SKIP_FRAMES-1, go to CAP and pulse frame_start. If SKIP_FRAMES=0, WAIT -> CAP directly on the first vs_rise.
  - CAP: each vs_rise ends the current frame and begins a new one. In the same cycle: pulse frame_done, load frame_words from word_cnt, clear word_cnt, pulse frame_start, clear line_err.
  - ANY -> IDLE when ddr_init_done=0. The in-progress word is discarded, no frame_done is issued, no further wren.
- Byte pairing (CAP, href_q=1): byte phase 0 latches the high byte. Byte phase 1 forms pixel = {high byte, current byte}. Phase toggles every href_q cycle and clears on hr_rise.
- Line limits: a pixel is accepted only while pix_x < H_ACTIVE and line_y < V_ACTIVE. pix_x clears on hr_rise. line_y increments on hr_fall and clears on vs_rise.
- Packing order: pixel 0 of each group goes to [63:48], pixel 1 to [47:32], pixel 2 to [31:16], pixel 3 to [15:0]. Pixel bits are placed unchanged.
- Write timing: on acceptance of pixel 3, ddr_wren=1 with the full ddr_wdata on the next clock, for exactly one cycle. word_cnt increments with each wren.
- Throughput: at most one wren per 8 cmos_clk, so there is no backpressure.
- Malformed line: at hr_fall, if byte phase=1 or pixel-in-group≠0, set line_err and discard the partial word with no wren. Pixel-in-group clears at every hr_fall.
- vs_rise while href_q=1: treated as a frame boundary. Any partial word is discarded and line_err is set.
- A full H_ACTIVE=1280 line yields 320 words. A full frame yields 230400 words.
- frame_words saturates at 2^20-1.

Test Plan:
- Init gating: hold ddr_init_done=0 and send 3 frames -> no wren and no frame_start. Raise init with SKIP_FRAMES=2 -> the first frame_start comes at the 3rd vs_rise after init.
- Packing: one 4-pixel line with bytes 01 02 03 04 05 06 07 08 -> one wren with ddr_wdata=0x0102030405060708, one cycle after the byte 08 sample.
- Full frame with H_ACTIVE=1280, V_ACTIVE=720 and 730 lines of 1290 pixels -> 230400 wren. The next vs_rise gives frame_done=1 and frame_words=230400, with frame_start in the same cycle.
- Odd line: a line of 6 pixels -> one wren, line_err=1 and the partial word dropped. line_err clears at the next frame_start.
- Odd byte count: a line of 9 bytes -> the last byte is dropped and line_err=1.
- Abort cases:
  - Drop ddr_init_done mid-line -> no further wren and the FSM returns to IDLE.
  - Assert cmos_rst asynchronously mid-word -> all outputs 0 immediately.
